ascii_hex_parser: RTL and testbench
===================================

# ascii_hex_parser

Streaming ASCII-to-binary hex parser: consumes one character per handshake and assembles whitespace-delimited hexadecimal tokens into binary words. It is the receive-side counterpart of the nibble-to-ASCII digit encoder used by the console/debug output path. It sits between the serial/console character source and consumers such as the loader or debug monitor. It accepts both upper- and lower-case hex letters, so any text the encoder produces (including its mixed-case 'b' and 'd') round-trips.

## Interface
- DIGITS, default 8: maximum hex digits per token; the word is 4*DIGITS bits (32 by default).
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- in_char  in  8  ASCII character.
- in_valid  in  1  in_char is valid.
- in_ready  out  1  parser accepts in_char this cycle.
- out_word  out  4*DIGITS  assembled value, right-aligned.
- out_count  out  $clog2(DIGITS+1)  hex digits in the token; saturates at DIGITS.
- out_err  out  1  token had an invalid character or more than DIGITS digits.
- out_valid  out  1  out_word, out_count and out_err are valid.
- out_ready  in  1  consumer accepts the output.

## Operation
- Character classes:
  - hex: 0x30–0x39 (value c-0x30); 0x41–0x46 and 0x61–0x66 (value 10–15).
  - delimiter: 0x20, 0x09, 0x0A, 0x0D.
  - invalid: everything else.
- A character is consumed on any cycle with in_valid && in_ready.
- IDLE (skip delimiters):
  - delimiter: consumed, no effect.
  - hex: acc = value, cnt = 1, err = 0; go to ACCUM.
  - invalid: acc = 0, cnt = 0, err = 1; go to EMIT.
- ACCUM:
  - hex: acc = {acc[4*DIGITS-5:0], value}, keeping the last DIGITS digits.
  - hex with cnt already DIGITS: cnt holds at DIGITS; err = 1 (overflow).
  - delimiter: go to EMIT with acc/cnt/err unchanged.
  - invalid: err = 1; go to EMIT. The invalid character is consumed and not included in acc.
- EMIT:
  - out_valid = 1 and outputs show the registered acc/cnt/err; in_ready = 0.
  - On out_valid && out_ready, go to IDLE.
  - Outputs hold stable while out_ready is low.
- in_ready = 1 in IDLE and ACCUM, 0 in EMIT; it depends only on state.
- Reset mid-token or mid-EMIT discards the partial or pending word with no output.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_word 0, out_count 0, out_err 0.
- Outputs are registered; out_valid rises the cycle after the terminating character is accepted (latency 1).
- After the out_valid && out_ready cycle, out_valid is 0 and in_ready is 1 on the next cycle. The minimum token period is N+2 cycles for N digits plus one delimiter.
- Idle characters (in_valid=0) never change state. A token left in ACCUM waits indefinitely for its delimiter.
- out_word, out_count and out_err may change only on entry to EMIT or reset; they retain their last value in IDLE/ACCUM.
- in_char is ignored when in_valid is 0 or in_ready is 0.

## Test plan
- Reset, then stream "1A2b\n" with in_valid held high: in_ready drops after '\n' is accepted; the next cycle shows out_valid=1, out_word=0x00001A2B, out_count=4, out_err=0.
- Stream "  dEaDbEeF " with out_ready held low for 5 cycles: leading spaces are skipped; out_word=0xDEADBEEF, out_count=8, out_err=0, all stable until out_ready; in_ready=0 throughout.
- Stream "123456789 ": out_word=0x23456789, out_count=8, out_err=1.
- Stream "12G" then "34 ": first output word 0x12, count 2, err 1 on 'G'. Parsing resumes in IDLE and the second output is word 0x34, count 2, err 0.
- Stream "\tZ": output word 0, count 0, err 1 on 'Z'. A lone "\r\n\t " stream produces no output.
- Stream "ABC", pull reset_n low for 1 cycle, then stream "5\n": only one output, word 0x5, count 1. After the reset assertion all outputs read their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ascii_hex_parser.sv
// Streaming ASCII hex tokenizer: whitespace-delimited hex digits in, binary words out.
// One character per in_valid/in_ready handshake; one word per out_valid/out_ready handshake.
module ascii_hex_parser #(
   parameter int DIGITS = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [7:0]                   in_char,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [4*DIGITS-1:0]          out_word,
   output logic [$clog2(DIGITS+1)-1:0]  out_count,
   output logic                         out_err,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic [W-1:0]    word_q, word_d;
   logic [CW-1:0]   count_q, count_d;
   logic            oerr_q, oerr_d;

   logic            is_hex, is_delim, take, cnt_full;
   logic [3:0]      hex_val;

   always_comb begin
      is_hex   = 1'b0;
      hex_val  = in_char[3:0];
      is_delim = (in_char == 8'h20) || (in_char == 8'h09) ||
                 (in_char == 8'h0A) || (in_char == 8'h0D);
      if (in_char >= 8'h30 && in_char <= 8'h39) begin
         is_hex = 1'b1;
      end else if ((in_char >= 8'h41 && in_char <= 8'h46) ||
                   (in_char >= 8'h61 && in_char <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
         is_hex  = 1'b1;
         hex_val = in_char[3:0] + 4'd9;
      end
   end

   assign in_ready  = (state_q != S_EMIT);
   assign out_valid = (state_q == S_EMIT);
   assign out_word  = word_q;
   assign out_count = count_q;
   assign out_err   = oerr_q;
   assign take      = in_valid && in_ready;
   assign cnt_full  = (cnt_q == CW'(DIGITS));

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      word_d  = word_q;
      count_d = count_q;
      oerr_d  = oerr_q;
      case (state_q)
         S_IDLE: begin
            if (take) begin
               if (is_hex) begin
                  acc_d   = W'(hex_val);
                  cnt_d   = CW'(1);
                  err_d   = 1'b0;
                  state_d = S_ACCUM;
               end else if (!is_delim) begin
                  acc_d   = '0;
                  cnt_d   = '0;
                  err_d   = 1'b1;
                  word_d  = '0;
                  count_d = '0;
                  oerr_d  = 1'b1;
                  state_d = S_EMIT;
               end
            end
         end
         S_ACCUM: begin
            if (take) begin
               if (is_hex) begin
                  // overflow keeps the most recent DIGITS digits
                  acc_d = {acc_q[W-5:0], hex_val};
                  cnt_d = cnt_full ? cnt_q : cnt_q + CW'(1);
                  err_d = err_q | cnt_full;
               end else begin
                  err_d   = err_q | ~is_delim;
                  word_d  = acc_q;
                  count_d = cnt_q;
                  oerr_d  = err_q | ~is_delim;
                  state_d = S_EMIT;
               end
            end
         end
         S_EMIT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         word_q  <= '0;
         count_q <= '0;
         oerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         word_q  <= word_d;
         count_q <= count_d;
         oerr_q  <= oerr_d;
      end
   end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Directed bench for ascii_hex_parser: token table plus hand sequences for stall and reset.
module tb_ascii_hex_parser;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  in_char;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_word;
   logic [3:0]  out_count;
   logic        out_err;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] w;
      logic [3:0]  c;
      logic        e;
   } obs_t;
   obs_t obs_q[$];

   typedef struct {
      string       s;
      int          nout;
      logic [31:0] w;
      logic [3:0]  c;
      logic        e;
   } vec_t;

   ascii_hex_parser #(.DIGITS(8)) dut (
      .clk(clk), .reset_n(reset_n), .in_char(in_char), .in_valid(in_valid),
      .in_ready(in_ready), .out_word(out_word), .out_count(out_count),
      .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // record every output handshake
   always @(negedge clk) begin
      if (out_valid && out_ready) obs_q.push_back({out_word, out_count, out_err});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send_char(input logic [7:0] c);
      logic acc;
      acc = 1'b0;
      in_char  = c;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = in_ready;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_char(s[i]);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((out_valid || !in_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("idle_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic chk_obs(input string name, input logic [31:0] w, input logic [3:0] c, input logic e);
      obs_t o;
      if (obs_q.size() == 0) begin
         chk({name, "_present"}, 32'd0, 32'd1);
      end else begin
         o = obs_q.pop_front();
         chk({name, "_word"}, o.w, w);
         chk({name, "_count"}, 32'(o.c), 32'(c));
         chk({name, "_err"}, 32'(o.e), 32'(e));
      end
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{"1A2b\n",       1, 32'h00001A2B, 4'd4, 1'b0};
      vecs[1] = '{"123456789 ",   1, 32'h23456789, 4'd8, 1'b1};
      vecs[2] = '{"\tZ",          1, 32'h00000000, 4'd0, 1'b1};
      vecs[3] = '{"ff\015",       1, 32'h000000FF, 4'd2, 1'b0};
      vecs[4] = '{"0 ",           1, 32'h00000000, 4'd1, 1'b0};
      vecs[5] = '{"a5x",          1, 32'h000000A5, 4'd2, 1'b1};
      vecs[6] = '{"\015\n\t ",    0, 32'h0,        4'd0, 1'b0};

      reset_n   = 1'b0;
      in_char   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_word", out_word, 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_err", 32'(out_err), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // latency: out_valid the cycle after the delimiter is accepted
      out_ready = 1'b0;
      send_str("1A2b\n");
      chk("lat_out_valid", 32'(out_valid), 32'd1);
      chk("lat_in_ready", 32'(in_ready), 32'd0);
      chk("lat_word", out_word, 32'h00001A2B);
      out_ready = 1'b1;
      wait_idle();
      chk_obs("lat", 32'h00001A2B, 4'd4, 1'b0);

      foreach (vecs[k]) begin
         send_str(vecs[k].s);
         wait_idle();
         chk($sformatf("v%0d_nout", k), 32'(obs_q.size()), 32'(vecs[k].nout));
         if (vecs[k].nout == 1) chk_obs($sformatf("v%0d", k), vecs[k].w, vecs[k].c, vecs[k].e);
         obs_q.delete();
      end

      // back-pressure: outputs hold while out_ready is low
      out_ready = 1'b0;
      send_str("  dEaDbEeF ");
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_word", out_word, 32'hDEADBEEF);
         @(negedge clk);
      end
      out_ready = 1'b1;
      wait_idle();
      chk("stall_nout", 32'(obs_q.size()), 32'd1);
      chk_obs("stall", 32'hDEADBEEF, 4'd8, 1'b0);
      obs_q.delete();

      // invalid char ends a token and parsing resumes
      send_str("12G34 ");
      wait_idle();
      chk("resume_nout", 32'(obs_q.size()), 32'd2);
      chk_obs("resume0", 32'h00000012, 4'd2, 1'b1);
      chk_obs("resume1", 32'h00000034, 4'd2, 1'b0);
      obs_q.delete();

      // reset mid-token discards it; outputs clear asynchronously
      send_str("ABC");
      #1 reset_n = 1'b0;
      #1;
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_word", out_word, 32'd0);
      chk("arst_count", 32'(out_count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      send_str("5\n");
      wait_idle();
      chk("arst_nout", 32'(obs_q.size()), 32'd1);
      chk_obs("arst", 32'h00000005, 4'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
